// File: rtl/game_state_ctrl.sv
// Game sequencer and collision judge: frame strobe, start-key debounce,
// bird-vs-pipe/ground/ceiling hit detection, pipe scoring and IDLE/PLAY/DEAD/OVER FSM.
module game_state_ctrl #(
    parameter int unsigned FRAME_DIV    = 1083333,
    parameter int unsigned DEBOUNCE_CYC = 650000,
    parameter int unsigned DEATH_FRAMES = 60,
    parameter int unsigned BIRD_W       = 40,
    parameter int unsigned BIRD_H       = 35,
    parameter int unsigned PIPE_W       = 80,
    parameter int unsigned GAP_H        = 180,
    parameter int unsigned GROUND_Y     = 668
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_start,
    input  logic [11:0] bird_x,
    input  logic [11:0] bird_y,
    input  logic [11:0] pipe0_x,
    input  logic [11:0] pipe0_gap_y,
    input  logic [11:0] pipe1_x,
    input  logic [11:0] pipe1_gap_y,
    output logic        frame_pulse,
    output logic        game_active,
    output logic        game_over,
    output logic [1:0]  state,
    output logic [7:0]  score
);

    localparam int unsigned FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned CW = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
    localparam int unsigned SW = 13;

    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] DEATH_LAST = CW'(DEATH_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2,
        OVER = 2'd3
    } state_t;

    state_t          st;
    logic [FW-1:0]   frame_cnt;
    logic [FW-1:0]   frame_cnt_nxt;
    logic            key_s1;
    logic            key_s2;
    logic            key_level;
    logic            key_press;
    logic [DW-1:0]   deb_cnt;
    logic            hit;
    logic            hit_r;
    logic [1:0]      clear;
    logic [1:0]      passed;
    logic [CW-1:0]   death_cnt;
    logic [1:0]      gain;
    logic [8:0]      score_sum;
    logic [7:0]      score_sat;
    logic [SW-1:0]   bird_r;
    logic [SW-1:0]   bird_b;
    logic [2:0]      pipe0_res;
    logic [2:0]      pipe1_res;

    assign state = st;

    // Per-pipe judgement in 13-bit arithmetic: {x overlap, y outside gap, pipe cleared}
    function automatic logic [2:0] pipe_eval(input logic [11:0] px, input logic [11:0] gy,
                                             input logic [11:0] bx, input logic [11:0] by);
        logic [SW-1:0] p_r;
        logic [SW-1:0] g_b;
        logic [SW-1:0] b_r;
        logic [SW-1:0] b_b;
        logic          xov;
        logic          yout;
        logic          clr;
        p_r  = {1'b0, px} + SW'(PIPE_W);
        g_b  = {1'b0, gy} + SW'(GAP_H);
        b_r  = {1'b0, bx} + SW'(BIRD_W);
        b_b  = {1'b0, by} + SW'(BIRD_H);
        xov  = (b_r > {1'b0, px}) && ({1'b0, bx} < p_r);
        yout = (by < gy) || (b_b > g_b);
        clr  = (p_r < {1'b0, bx});
        return {xov, yout, clr};
    endfunction

    // Frame counter next value; the strobe is registered one cycle early so it lines up with the last count
    always_comb begin
        frame_cnt_nxt = frame_cnt + FW'(1);
        if (frame_cnt == FRAME_LAST) begin
            frame_cnt_nxt = '0;
        end
    end

    // Free-running frame counter and strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            frame_pulse <= 1'b0;
        end else begin
            frame_cnt   <= frame_cnt_nxt;
            frame_pulse <= (frame_cnt_nxt == FRAME_LAST);
        end
    end

    // Start key synchroniser, stability counter and rising-edge pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1    <= 1'b0;
            key_s2    <= 1'b0;
            key_level <= 1'b0;
            key_press <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            key_s1    <= key_start;
            key_s2    <= key_s1;
            key_press <= 1'b0;
            if (key_s2 == key_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt   <= '0;
                key_level <= key_s2;
                key_press <= key_s2;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    // Combined hit and per-frame score gain
    always_comb begin
        bird_r    = {1'b0, bird_x} + SW'(BIRD_W);
        bird_b    = {1'b0, bird_y} + SW'(BIRD_H);
        pipe0_res = pipe_eval(pipe0_x, pipe0_gap_y, bird_x, bird_y);
        pipe1_res = pipe_eval(pipe1_x, pipe1_gap_y, bird_x, bird_y);
        clear     = {pipe1_res[0], pipe0_res[0]};
        hit       = (pipe0_res[2] && pipe0_res[1]) || (pipe1_res[2] && pipe1_res[1]) ||
                    (bird_b >= SW'(GROUND_Y)) || (bird_y == 12'd0);
        gain      = 2'(clear[0] && !passed[0]) + 2'(clear[1] && !passed[1]);
        score_sum = {1'b0, score} + 9'(gain);
        score_sat = (score_sum > 9'd255) ? 8'hFF : score_sum[7:0];
    end

    // Collision register, sampled every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_r <= 1'b0;
        end else begin
            hit_r <= hit;
        end
    end

    // Game FSM with scoring, death timer and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            score       <= 8'd0;
            passed      <= 2'b00;
            death_cnt   <= '0;
            game_active <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            // a pipe that is no longer behind the bird has respawned and may score again
            passed <= passed & clear;
            case (st)
                IDLE: begin
                    if (key_press) begin
                        st          <= PLAY;
                        game_active <= 1'b1;
                        score       <= 8'd0;
                        passed      <= 2'b00;
                        death_cnt   <= '0;
                    end
                end
                PLAY: begin
                    if (frame_pulse) begin
                        if (hit_r) begin
                            st          <= DEAD;
                            game_active <= 1'b0;
                        end else begin
                            score  <= score_sat;
                            passed <= clear;
                        end
                    end
                end
                DEAD: begin
                    if (frame_pulse) begin
                        if (death_cnt == DEATH_LAST) begin
                            st        <= OVER;
                            game_over <= 1'b1;
                            death_cnt <= '0;
                        end else begin
                            death_cnt <= death_cnt + CW'(1);
                        end
                    end
                end
                OVER: begin
                    if (key_press) begin
                        st        <= IDLE;
                        game_over <= 1'b0;
                    end
                end
                default: begin
                    st          <= IDLE;
                    game_active <= 1'b0;
                    game_over   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with shortened frame/debounce/death timing.
module tb_game_state_ctrl;

    logic        clk;
    logic        rst_n;
    logic        key_start;
    logic [11:0] bird_x;
    logic [11:0] bird_y;
    logic [11:0] pipe0_x;
    logic [11:0] pipe0_gap_y;
    logic [11:0] pipe1_x;
    logic [11:0] pipe1_gap_y;
    logic        frame_pulse;
    logic        game_active;
    logic        game_over;
    logic [1:0]  state;
    logic [7:0]  score;

    int checks = 0;
    int errors = 0;

    game_state_ctrl #(
        .FRAME_DIV    (16),
        .DEBOUNCE_CYC (4),
        .DEATH_FRAMES (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_start   (key_start),
        .bird_x      (bird_x),
        .bird_y      (bird_y),
        .pipe0_x     (pipe0_x),
        .pipe0_gap_y (pipe0_gap_y),
        .pipe1_x     (pipe1_x),
        .pipe1_gap_y (pipe1_gap_y),
        .frame_pulse (frame_pulse),
        .game_active (game_active),
        .game_over   (game_over),
        .state       (state),
        .score       (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] bx;
        logic [11:0] by;
        logic [11:0] p0x;
        logic [11:0] p0g;
        logic [11:0] p1x;
        logic [11:0] p1g;
        int          exp_st;
        int          exp_sc;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input int bx, input int by, input int p0x, input int p0g,
                          input int p1x, input int p1g);
        bird_x      = 12'(bx);
        bird_y      = 12'(by);
        pipe0_x     = 12'(p0x);
        pipe0_gap_y = 12'(p0g);
        pipe1_x     = 12'(p1x);
        pipe1_gap_y = 12'(p1g);
    endtask

    // Reset with harmless inputs (no hit, no clear)
    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        key_start = 1'b0;
        set_in(300, 250, 1000, 200, 1000, 200);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Hold key for n cycles, then release and let the debouncer settle; lat = first cycle state moved
    task automatic press_key(input int n, output int lat);
        logic [1:0] st0;
        st0 = state;
        lat = 0;
        key_start = 1'b1;
        for (int i = 1; i <= n + 12; i++) begin
            @(negedge clk);
            if (i == n) key_start = 1'b0;
            if (lat == 0 && state != st0) lat = i;
        end
    endtask

    // Wait for the next frame strobe (bounded) and land on the negedge after it is consumed
    task automatic next_frame();
        logic found;
        found = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (frame_pulse) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("frame_seen", int'(found), 1);
        @(negedge clk);
    endtask

    task automatic start_game();
        int lat;
        do_reset();
        press_key(6, lat);
        check("start_state", int'(state), 1);
    endtask

    initial begin
        int lat;
        int pulse_at;
        int pulse2_at;

        vecs[0]  = '{12'd300, 12'd100, 12'd320,  12'd200, 12'd1000, 12'd200, 2, 0};
        vecs[1]  = '{12'd300, 12'd250, 12'd320,  12'd200, 12'd1000, 12'd200, 1, 0};
        vecs[2]  = '{12'd300, 12'd346, 12'd320,  12'd200, 12'd1000, 12'd200, 2, 0};
        vecs[3]  = '{12'd300, 12'd345, 12'd320,  12'd200, 12'd1000, 12'd200, 1, 0};
        vecs[4]  = '{12'd300, 12'd200, 12'd320,  12'd200, 12'd1000, 12'd200, 1, 0};
        vecs[5]  = '{12'd300, 12'd199, 12'd320,  12'd200, 12'd1000, 12'd200, 2, 0};
        vecs[6]  = '{12'd280, 12'd100, 12'd320,  12'd200, 12'd1000, 12'd200, 1, 0};
        vecs[7]  = '{12'd400, 12'd100, 12'd320,  12'd200, 12'd1000, 12'd200, 1, 0};
        vecs[8]  = '{12'd300, 12'd100, 12'd1000, 12'd200, 12'd320,  12'd200, 2, 0};
        vecs[9]  = '{12'd300, 12'd633, 12'd1000, 12'd200, 12'd1000, 12'd200, 2, 0};
        vecs[10] = '{12'd300, 12'd632, 12'd1000, 12'd200, 12'd1000, 12'd200, 1, 0};
        vecs[11] = '{12'd300, 12'd0,   12'd1000, 12'd200, 12'd1000, 12'd200, 2, 0};
        vecs[12] = '{12'd300, 12'd250, 12'd200,  12'd200, 12'd1000, 12'd200, 1, 1};
        vecs[13] = '{12'd300, 12'd250, 12'd200,  12'd200, 12'd100,  12'd200, 1, 2};
        vecs[14] = '{12'd300, 12'd0,   12'd200,  12'd200, 12'd100,  12'd200, 2, 0};
        vecs[15] = '{12'd401, 12'd100, 12'd320,  12'd200, 12'd1000, 12'd200, 1, 1};

        rst_n     = 1'b0;
        key_start = 1'b0;
        set_in(300, 250, 1000, 200, 1000, 200);

        // Reset values
        #12;
        check("rst_state", int'(state), 0);
        check("rst_score", int'(score), 0);
        check("rst_frame_pulse", int'(frame_pulse), 0);
        check("rst_game_active", int'(game_active), 0);
        check("rst_game_over", int'(game_over), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Short key bounce is rejected, a held key starts the game
        press_key(3, lat);
        check("short_key_lat", lat, 0);
        check("short_key_state", int'(state), 0);
        press_key(6, lat);
        check("start_latency_ok", int'(lat > 0 && lat <= 8), 1);
        check("start_state1", int'(state), 1);
        check("start_active", int'(game_active), 1);

        // Table: one frame of judgement from a fresh game
        foreach (vecs[i]) begin
            start_game();
            @(negedge clk);
            set_in(vecs[i].bx, vecs[i].by, vecs[i].p0x, vecs[i].p0g, vecs[i].p1x, vecs[i].p1g);
            next_frame();
            check($sformatf("vec%0d_state", i), int'(state), vecs[i].exp_st);
            check($sformatf("vec%0d_score", i), int'(score), vecs[i].exp_sc);
            check($sformatf("vec%0d_active", i), int'(game_active), int'(vecs[i].exp_st == 1));
        end

        // Death timer then restart to IDLE
        start_game();
        set_in(300, 100, 320, 200, 1000, 200);
        next_frame();
        check("death_state", int'(state), 2);
        next_frame();
        next_frame();
        check("dead_after2", int'(state), 2);
        check("dead_over_low", int'(game_over), 0);
        next_frame();
        check("over_state", int'(state), 3);
        check("over_flag", int'(game_over), 1);
        press_key(6, lat);
        check("over_to_idle", int'(state), 0);
        check("idle_over_low", int'(game_over), 0);

        // Gap pass and repeated clears of one pipe
        start_game();
        set_in(300, 250, 320, 200, 1000, 200);
        next_frame();
        check("gap_state", int'(state), 1);
        check("gap_score0", int'(score), 0);
        pipe0_x = 12'd200;
        next_frame();
        check("gap_score1", int'(score), 1);
        next_frame();
        check("gap_score1_hold", int'(score), 1);
        pipe0_x = 12'd900;
        next_frame();
        check("gap_score_respawn", int'(score), 1);
        pipe0_x = 12'd200;
        next_frame();
        check("gap_score2", int'(score), 2);

        // Saturation: 127 double clears, then two more
        start_game();
        set_in(300, 250, 1000, 200, 1000, 200);
        for (int k = 0; k < 127; k++) begin
            pipe0_x = 12'd1000;
            pipe1_x = 12'd1000;
            @(negedge clk);
            pipe0_x = 12'd200;
            pipe1_x = 12'd100;
            next_frame();
        end
        check("preload_254", int'(score), 254);
        pipe0_x = 12'd1000;
        pipe1_x = 12'd1000;
        @(negedge clk);
        pipe0_x = 12'd200;
        pipe1_x = 12'd100;
        next_frame();
        check("sat_255", int'(score), 255);
        pipe0_x = 12'd1000;
        pipe1_x = 12'd1000;
        @(negedge clk);
        pipe0_x = 12'd200;
        bird_y  = 12'd0;
        next_frame();
        check("clear_hit_state", int'(state), 2);
        check("clear_hit_score", int'(score), 255);
        repeat (3) next_frame();
        check("sat_over", int'(state), 3);
        press_key(6, lat);
        check("idle_score_hold", int'(score), 255);
        set_in(300, 250, 1000, 200, 1000, 200);
        press_key(6, lat);
        check("replay_score_clr", int'(score), 0);

        // Mid-game asynchronous reset and frame counter restart
        start_game();
        set_in(300, 250, 200, 200, 100, 200);
        next_frame();
        set_in(300, 250, 1000, 200, 1000, 200);
        @(negedge clk);
        set_in(300, 250, 200, 200, 100, 200);
        next_frame();
        set_in(300, 250, 1000, 200, 1000, 200);
        @(negedge clk);
        pipe0_x = 12'd200;
        next_frame();
        check("mid_score5", int'(score), 5);
        #2 rst_n = 1'b0;
        #1;
        check("async_state", int'(state), 0);
        check("async_score", int'(score), 0);
        check("async_active", int'(game_active), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_at  = 0;
        pulse2_at = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (frame_pulse) begin
                if (pulse_at == 0) pulse_at = i;
                else if (pulse2_at == 0) pulse2_at = i;
            end
        end
        check("frame_restart", pulse_at, 15);
        check("frame_period", pulse2_at - pulse_at, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
